bcd_convert_scheduler: RTL



---
 rtl/bcd_convert_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler
//   Shared iterative binary-to-BCD converter (double dabble, one bit per clock)
//   serving two requesters through round-robin arbitration.
//
//   clk, rst              : clock, synchronous active-high reset
//   a_valid/a_ready/a_bin : requester A hand-over (valid/ready)
//   b_valid/b_ready/b_bin : requester B hand-over (valid/ready)
//   out_valid/out_ready   : result channel
//   out_bcd               : packed BCD, digit 0 in [3:0], saturated to all 9s on overflow
//   out_id                : 0 = result for A, 1 = result for B
//   out_ovf               : input exceeded MAX_VAL
//   busy                  : converter not idle
module bcd_convert_scheduler #(
  parameter int unsigned IN_W    = 27,
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned MAX_VAL = 99999999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [IN_W-1:0]       a_bin,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [IN_W-1:0]       b_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_id,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int unsigned       BCD_W   = 4 * DIGITS;
  localparam int unsigned       CNT_W   = (IN_W > 1) ? $clog2(IN_W) + 1 : 1;
  localparam logic [IN_W-1:0]   MAX_BIN = IN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(IN_W - 1);
  localparam logic [BCD_W-1:0]  SAT_BCD = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              grant_a;
  logic              grant_b;
  logic [IN_W-1:0]   sel_bin;
  logic              last_grant;   // 1 = B was granted last

  logic [IN_W-1:0]   shift_bin;
  logic [BCD_W-1:0]  bcd_acc;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  count;
  logic              id_q;
  logic              ovf_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin arbitration; A wins ties when B was served last
  always_comb begin
    grant_a = a_valid & (~b_valid | last_grant);
    grant_b = b_valid & ~grant_a;
    sel_bin = grant_a ? a_bin : b_bin;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_a | grant_b) state_nxt = SHIFT;
      SHIFT:   if (count == LAST)     state_nxt = DONE;
      DONE:    if (out_valid & out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    a_ready = (state == IDLE) & grant_a;
    b_ready = (state == IDLE) & grant_b;
    busy    = (state != IDLE);
  end

  // Add-3 correction on every digit >= 5, ahead of the shift
  always_comb begin
    bcd_adj = bcd_acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Datapath and registered result channel.
  // DONE spends its first cycle loading the result registers, so out_valid
  // rises one edge after the final shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_bin  <= '0;
      bcd_acc    <= '0;
      count      <= '0;
      id_q       <= 1'b0;
      ovf_q      <= 1'b0;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_bcd    <= '0;
      out_id     <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a | grant_b) begin
            shift_bin  <= sel_bin;
            bcd_acc    <= '0;
            count      <= '0;
            id_q       <= grant_b;
            last_grant <= grant_b;
            ovf_q      <= (sel_bin > MAX_BIN);
          end
        end
        SHIFT: begin
          {bcd_acc, shift_bin} <= {bcd_adj, shift_bin} << 1;
          count                <= count + CNT_W'(1);
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_bcd   <= ovf_q ? SAT_BCD : bcd_acc;
            out_id    <= id_q;
            out_ovf   <= ovf_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
